// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Resolves memory wait, load-use and redirect hazards.
// Also tracks the memory-wait timeout and keeps saturating event counters.
//
// state    | meaning
// ---------+---------------------------------------------------------
// RUN      | normal flow; a new memory request that is not ready stalls
// MEM_WAIT | waiting on data memory; the wait timer counts cycles
// HALT     | memory timed out; pipeline frozen until rst
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_EX,
    input  logic             RegWrite_EX,
    input  logic             DatatoReg_EX,
    input  logic             redirect_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    output logic             PC_EN,
    output logic             IFID_EN,
    output logic             IFID_flush,
    output logic             IDEX_EN,
    output logic             IDEX_flush,
    output logic             EXMEM_EN,
    output logic             MEMWB_flush,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    localparam logic [7:0]       TIMEOUT_LIM = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

    logic mem_stall;
    logic load_use;
    logic redirect_act;
    logic load_use_act;

    // Hazard detection; masked hazards stay on the inputs of the frozen pipeline
    // and are picked up again on the release cycle.
    always_comb begin
        mem_stall = ((state_q == RUN) && mem_req_MEM && !mem_ready) ||
                    ((state_q == MEM_WAIT) && !mem_ready) ||
                    (state_q == HALT);
        load_use  = DatatoReg_EX && RegWrite_EX && (rd_EX != 5'd0) &&
                    ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                     (rs2_used_ID && (rs2_ID == rd_EX)));
        redirect_act = !mem_stall && redirect_EX;
        load_use_act = !mem_stall && !redirect_EX && load_use;
    end

    // Next-state, wait timer and sticky timeout flag; ready beats the timeout.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                timer_d = 8'd0;
                if (mem_req_MEM && !mem_ready) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                    timer_d = 8'd0;
                end else begin
                    timer_d = timer_q + 8'd1;
                    if (timer_d >= TIMEOUT_LIM) begin
                        state_d = HALT;
                        err_d   = 1'b1;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
                timer_d = 8'd0;
            end
        endcase
    end

    // Enables and flushes by priority; everything is held inactive during reset.
    always_comb begin
        PC_EN       = 1'b1;
        IFID_EN     = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_EN     = 1'b1;
        IDEX_flush  = 1'b0;
        EXMEM_EN    = 1'b1;
        MEMWB_flush = 1'b0;
        if (rst) begin
            PC_EN    = 1'b0;
            IFID_EN  = 1'b0;
            IDEX_EN  = 1'b0;
            EXMEM_EN = 1'b0;
        end else if (mem_stall) begin
            PC_EN       = 1'b0;
            IFID_EN     = 1'b0;
            IDEX_EN     = 1'b0;
            EXMEM_EN    = 1'b0;
            MEMWB_flush = 1'b1;
        end else if (redirect_EX) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (load_use) begin
            PC_EN      = 1'b0;
            IFID_EN    = 1'b0;
            IDEX_flush = 1'b1;
        end
    end

    // State, timer, error flag and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            timer_q       <= 8'd0;
            err_q         <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            if (load_use_act && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (redirect_act && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
            if (mem_stall && (memwait_cnt_q != CNT_MAX)) begin
                memwait_cnt_q <= memwait_cnt_q + CNT_ONE;
            end
        end
    end

    assign mem_timeout_err = err_q;
    assign stall_cnt       = stall_cnt_q;
    assign flush_cnt       = flush_cnt_q;
    assign memwait_cnt     = memwait_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
// The vector table holds inputs and expected outputs per cycle. The counter
// fields hold the values expected before that cycle's clock edge.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic rs1_used_ID, rs2_used_ID, RegWrite_EX, DatatoReg_EX;
    logic redirect_EX, mem_req_MEM, mem_ready;
    logic PC_EN, IFID_EN, IFID_flush, IDEX_EN, IDEX_flush, EXMEM_EN, MEMWB_flush;
    logic mem_timeout_err;
    logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .RegWrite_EX(RegWrite_EX), .DatatoReg_EX(DatatoReg_EX),
        .redirect_EX(redirect_EX), .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
        .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IFID_flush(IFID_flush),
        .IDEX_EN(IDEX_EN), .IDEX_flush(IDEX_flush), .EXMEM_EN(EXMEM_EN),
        .MEMWB_flush(MEMWB_flush), .mem_timeout_err(mem_timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
    );

    always #5 clk = ~clk;

    // {PC_EN, IFID_EN, IFID_flush, IDEX_EN, IDEX_flush, EXMEM_EN, MEMWB_flush}
    localparam logic [6:0] O_RST = 7'b0000000;
    localparam logic [6:0] O_NRM = 7'b1101010;
    localparam logic [6:0] O_MEM = 7'b0000001;
    localparam logic [6:0] O_RED = 7'b1111110;
    localparam logic [6:0] O_LU  = 7'b0001110;

    typedef struct {
        logic          rst;
        logic [4:0]    rs1, rs2;
        logic          u1, u2;
        logic [4:0]    rd;
        logic          rw, dr, redir, req, rdy;
        logic [6:0]    exp_o;
        logic          exp_err;
        logic [CW-1:0] sc, fc, mc;
    } vec_t;

    typedef struct {
        logic [6:0]    o;
        logic          err;
        logic [CW-1:0] sc, fc, mc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic r, logic [4:0] s1, logic [4:0] s2, logic a1, logic a2,
                                logic [4:0] d, logic w, logic l, logic rd_i, logic q, logic y,
                                logic [6:0] eo, logic ee, int sc, int fc, int mc);
        vec_t v;
        v.rst = r; v.rs1 = s1; v.rs2 = s2; v.u1 = a1; v.u2 = a2; v.rd = d;
        v.rw = w; v.dr = l; v.redir = rd_i; v.req = q; v.rdy = y;
        v.exp_o = eo; v.exp_err = ee;
        v.sc = CW'(sc); v.fc = CW'(fc); v.mc = CW'(mc);
        return v;
    endfunction

    task automatic add_rst();
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0, 0, 0, 0));
    endtask

    task automatic add_idle(int sc, int fc, int mc, logic err);
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NRM, err, sc, fc, mc));
    endtask

    task automatic add_mem(logic q, logic y, logic [6:0] eo, logic err, int sc, int fc, int mc);
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, q, y, eo, err, sc, fc, mc));
    endtask

    task automatic check(string name, logic [6:0] eo, logic ee,
                         logic [CW-1:0] sc, logic [CW-1:0] fc, logic [CW-1:0] mc);
        logic [6:0] got_o;
        got_o = {PC_EN, IFID_EN, IFID_flush, IDEX_EN, IDEX_flush, EXMEM_EN, MEMWB_flush};
        n_vec++;
        if (got_o !== eo || mem_timeout_err !== ee || stall_cnt !== sc ||
            flush_cnt !== fc || memwait_cnt !== mc) begin
            n_bad++;
            $display("FAIL %s: got o=%b err=%b sc=%0d fc=%0d mc=%0d, want o=%b err=%b sc=%0d fc=%0d mc=%0d",
                     name, got_o, mem_timeout_err, stall_cnt, flush_cnt, memwait_cnt,
                     eo, ee, sc, fc, mc);
        end
    endtask

    initial begin
        exp_t e;
        int   cyc;

        rst = 1'b1;
        rs1_ID = 0; rs2_ID = 0; rs1_used_ID = 0; rs2_used_ID = 0; rd_EX = 0;
        RegWrite_EX = 0; DatatoReg_EX = 0; redirect_EX = 0; mem_req_MEM = 0; mem_ready = 0;

        // load-use, redirect priority
        add_rst();
        add_idle(0, 0, 0, 0);
        vecs.push_back(mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, O_LU,  0, 0, 0, 0));
        add_idle(1, 0, 0, 0);
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, O_NRM, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 7, 0, 1, 7, 1, 1, 0, 0, 0, O_LU,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 7, 0, 0, 7, 1, 1, 0, 0, 0, O_NRM, 0, 2, 0, 0));
        vecs.push_back(mk(0, 3, 0, 1, 0, 3, 0, 1, 0, 0, 0, O_NRM, 0, 2, 0, 0));
        vecs.push_back(mk(0, 5, 0, 1, 0, 5, 1, 1, 1, 0, 0, O_RED, 0, 2, 0, 0));
        add_idle(2, 1, 0, 0);
        // 3-cycle memory wait, then hazards held through a stall
        add_rst();
        add_mem(1, 0, O_MEM, 0, 0, 0, 0);
        add_mem(1, 0, O_MEM, 0, 0, 0, 1);
        add_mem(1, 0, O_MEM, 0, 0, 0, 2);
        add_mem(1, 1, O_NRM, 0, 0, 0, 3);
        add_mem(0, 0, O_NRM, 0, 0, 0, 3);
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_MEM, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_MEM, 0, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_RED, 0, 0, 0, 5));
        add_idle(0, 1, 5, 0);
        vecs.push_back(mk(0, 9, 0, 1, 0, 9, 1, 1, 0, 1, 0, O_MEM, 0, 0, 1, 5));
        vecs.push_back(mk(0, 9, 0, 1, 0, 9, 1, 1, 0, 1, 1, O_LU,  0, 0, 1, 6));
        add_idle(1, 1, 6, 0);
        // timeout into HALT, ready afterwards does not release
        add_rst();
        for (int i = 0; i < 5; i++) add_mem(1, 0, O_MEM, 0, 0, 0, i);
        add_mem(1, 0, O_MEM, 1, 0, 0, 5);
        add_mem(1, 1, O_MEM, 1, 0, 0, 6);
        add_mem(0, 1, O_MEM, 1, 0, 0, 7);
        add_rst();
        add_idle(0, 0, 0, 0);
        // ready on the very cycle the timer would expire completes the access
        for (int i = 0; i < 4; i++) add_mem(1, 0, O_MEM, 0, 0, 0, i);
        add_mem(1, 1, O_NRM, 0, 0, 0, 4);
        add_mem(0, 0, O_NRM, 0, 0, 0, 4);
        // flush_cnt saturation, then reset in MEM_WAIT
        add_rst();
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_RED, 0, 0, i, 0));
        add_idle(0, 15, 0, 0);
        add_mem(1, 0, O_MEM, 0, 0, 15, 0);
        add_mem(1, 0, O_MEM, 0, 0, 15, 1);
        add_rst();
        add_mem(0, 0, O_NRM, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            rs1_ID = vecs[i].rs1; rs2_ID = vecs[i].rs2;
            rs1_used_ID = vecs[i].u1; rs2_used_ID = vecs[i].u2;
            rd_EX = vecs[i].rd; RegWrite_EX = vecs[i].rw; DatatoReg_EX = vecs[i].dr;
            redirect_EX = vecs[i].redir; mem_req_MEM = vecs[i].req; mem_ready = vecs[i].rdy;
            e.o = vecs[i].exp_o; e.err = vecs[i].exp_err;
            e.sc = vecs[i].sc; e.fc = vecs[i].fc; e.mc = vecs[i].mc;
            sb.push_back(e);
            #2;
            e = sb.pop_front();
            check($sformatf("vec%0d", i), e.o, e.err, e.sc, e.fc, e.mc);
        end

        // Hand sequence: bounded wait for the timeout, then async reset out of HALT.
        @(negedge clk);
        rst = 1'b0; redirect_EX = 0; mem_req_MEM = 1; mem_ready = 0;
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mem_timeout_err === 1'b1) begin
                cyc = i;
                break;
            end
        end
        n_vec++;
        if (cyc != 5) begin
            n_bad++;
            $display("FAIL halt_latency: got %0d cycles, want 5", cyc);
        end
        mem_ready = 1;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_halt", O_RST, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; mem_req_MEM = 0; mem_ready = 0;
        #2;
        check("after_rst_run", O_NRM, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
